ff_pipe: RTL and testbench

Parametrised register pipeline: a WIDTH-bit data word travels with a valid flag through DEPTH clock-enabled stages. Reset is asynchronous, clear is synchronous, and a fill counter reports when the pipeline is primed. It is the generalised successor of the single-bit D flip-flop in the PWM datapath. It aligns duty-cycle and compare values with the PWM counter, and optionally exposes every stage as a tap.

---
 rtl/ff_pipe.sv | 88 ++++++++
 tb/tb_ff_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ff_pipe.sv
// rtl/ff_pipe.sv - clock-enabled data/valid register pipeline with fill tracking (optional taps via FF_PIPE_TAPS_EN)
//
// A WIDTH-bit word and its valid flag advance one stage per enabled edge
// through DEPTH stages. A saturating fill counter reports when DEPTH
// enabled advances have happened since the last reset or clear, so the
// word on q is no longer the reset value. Used to align duty-cycle
// and compare values with the PWM counter.
//
// Build option FF_PIPE_TAPS_EN: adds the taps port carrying every data
// stage (stage i at bits [i*WIDTH +: WIDTH]). Valid flags are not tapped.

module ff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_in,
  output logic [WIDTH-1:0] q,
  output logic             vld_out,
  output logic             primed
`ifdef FF_PIPE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0] taps
`endif
);

  // Fill counter must be able to hold the value DEPTH itself.
  localparam int             FCW    = $clog2(DEPTH + 1);
  localparam logic [FCW-1:0] FC_MAX = FCW'(DEPTH);
  localparam logic [FCW-1:0] FC_ONE = FCW'(1);

  logic [WIDTH-1:0] s [DEPTH];
  logic [DEPTH-1:0] v;
  logic [FCW-1:0]   fc;

  // Data stages: reset/clear load RST_VAL, enable shifts toward the output.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= RST_VAL;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= RST_VAL;
    end else if (en) begin
      s[0] <= d;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
    end
  end

  // Valid stages: follow the data exactly; a stalled word keeps its flag.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (clr) begin
      v <= '0;
    end else if (en) begin
      v[0] <= vld_in;
      for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
    end
  end

  // Fill counter: counts enabled advances and saturates at DEPTH, never wraps.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      fc <= '0;
    end else if (clr) begin
      fc <= '0;
    end else if (en && (fc < FC_MAX)) begin
      fc <= fc + FC_ONE;
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  assign q       = s[DEPTH-1];
  assign vld_out = v[DEPTH-1];
  assign primed  = (fc == FC_MAX);

`ifdef FF_PIPE_TAPS_EN
  // Expose every data stage, stage 0 in the least significant slice.
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = s[g];
  end
`endif

endmodule

// File: tb/tb_ff_pipe.sv
// tb/tb_ff_pipe.sv - self-checking bench for ff_pipe (DEPTH=3, RST_VAL=A5)

module tb_ff_pipe;

  localparam int         W   = 8;
  localparam int         DP  = 3;
  localparam logic [7:0] RV  = 8'hA5;

  logic         ck;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [W-1:0] d;
  logic         vld_in;
  logic [W-1:0] q;
  logic         vld_out;
  logic         primed;
`ifdef FF_PIPE_TAPS_EN
  logic [W*DP-1:0] taps;
`endif

  ff_pipe #(.WIDTH(W), .DEPTH(DP), .RST_VAL(RV)) dut (
    .ck      (ck),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .vld_in  (vld_in),
    .q       (q),
    .vld_out (vld_out),
    .primed  (primed)
`ifdef FF_PIPE_TAPS_EN
    ,
    .taps    (taps)
`endif
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Model: queue front = output stage, back = stage 0; each entry {vld, data}.
  logic [8:0] pipe [$];
  int         fill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe = {};
    for (int i = 0; i < DP; i++) pipe.push_back({1'b0, RV});
    fill = 0;
  endtask

  task automatic check_model(input string tag);
    logic [8:0] head;
    head = pipe[0];
    chk({tag, ".q"},      32'(q),       32'(head[7:0]));
    chk({tag, ".vld"},    32'(vld_out), 32'(head[8]));
    chk({tag, ".primed"}, 32'(primed),  32'(fill == DP));
  endtask

  // One clock edge with the given inputs; model updated, outputs checked 1 after the edge.
  task automatic step(input logic e, input logic c, input logic [7:0] dd, input logic vv,
                      input string tag);
    en = e; clr = c; d = dd; vld_in = vv;
    @(posedge ck);
    if (c) begin
      model_reset();
    end else if (e) begin
      pipe.push_back({vv, dd});
      void'(pipe.pop_front());
      if (fill < DP) fill++;
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; d = '0; vld_in = 1'b0;
    model_reset();

    // Asynchronous reset between edges, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst.q",      32'(q),       32'(RV));
    chk("rst.vld",    32'(vld_out), 32'(0));
    chk("rst.primed", 32'(primed),  32'(0));
    #4 rst_n = 1'b1;

    // Fill
    step(1, 0, 8'h01, 1, "fill1");
    chk("fill1.q_const", 32'(q), 32'(RV));
    step(1, 0, 8'h02, 1, "fill2");
    chk("fill2.q_const", 32'(q), 32'(RV));
    chk("fill2.primed_const", 32'(primed), 32'(0));
    step(1, 0, 8'h03, 1, "fill3");
    chk("fill3.q_const", 32'(q), 32'(8'h01));
    chk("fill3.vld_const", 32'(vld_out), 32'(1));
    chk("fill3.primed_const", 32'(primed), 32'(1));
    step(1, 0, 8'h04, 1, "fill4");
    chk("fill4.q_const", 32'(q), 32'(8'h02));
    step(1, 0, 8'h05, 1, "fill5");
    chk("fill5.q_const", 32'(q), 32'(8'h03));

    // Stall with changing d: everything frozen
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'($urandom), 1'($urandom), "stall");
      chk("stall.q_const", 32'(q), 32'(8'h03));
    end
    step(1, 0, 8'h06, 1, "resume");
    chk("resume.q_const", 32'(q), 32'(8'h04));

    // Clear wins over enable; FF never emerges
    step(1, 1, 8'hFF, 1, "clr");
    chk("clr.q_const",      32'(q),       32'(RV));
    chk("clr.vld_const",    32'(vld_out), 32'(0));
    chk("clr.primed_const", 32'(primed),  32'(0));

    // Mixed validity after a clean clear
    step(1, 0, 8'h10, 1, "mix1");
    step(1, 0, 8'h20, 0, "mix2");
    step(1, 0, 8'h30, 1, "mix3");
    chk("mix3.q_const", 32'({vld_out, q}), 32'({1'b1, 8'h10}));
    step(1, 0, 8'h00, 0, "mix4");
    chk("mix4.q_const", 32'({vld_out, q}), 32'({1'b0, 8'h20}));
    step(1, 0, 8'h00, 0, "mix5");
    chk("mix5.q_const", 32'({vld_out, q}), 32'({1'b1, 8'h30}));

    // Saturation: many enabled edges keep primed high, no wrap
    for (int i = 0; i < 10; i++) step(1, 0, 8'(i), 1, "sat");

    // Taps
    step(1, 0, 8'h11, 1, "tap1");
    step(1, 0, 8'h22, 1, "tap2");
    step(1, 0, 8'h33, 1, "tap3");
`ifdef FF_PIPE_TAPS_EN
    chk("taps.s0", 32'(taps[7:0]),   32'(8'h33));
    chk("taps.s1", 32'(taps[15:8]),  32'(8'h22));
    chk("taps.s2", 32'(taps[23:16]), 32'(8'h11));
`endif

    // Reset mid-stream: in-flight words discarded immediately
    step(1, 0, 8'h44, 1, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.q",      32'(q),       32'(RV));
    chk("midrst.vld",    32'(vld_out), 32'(0));
    chk("midrst.primed", 32'(primed),  32'(0));
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, "post_rst");

    // Clear alone, then random traffic against the model
    step(0, 1, 8'h5A, 1, "clr_only");
    for (int i = 0; i < 40; i++)
      step(1'($urandom), ($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
